// File: rtl/celement_pkg.sv
// celement_pkg
//   Shared definitions for the celement_mg merge element: handshake FSM state
//   encoding, branch (source) codes, default payload width and the
//   round-robin pick used by the arbiter.
package celement_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Source codes reported on BROUT and kept in the LAST register.
  localparam logic BR_A = 1'b0;
  localparam logic BR_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ACKUP = 2'd2,
    REL   = 2'd3
  } state_e;

  // Returns the source to grant given the two pending requests and the side
  // that completed the previous transfer. On a tie the side opposite LAST wins.
  // With no request pending the result is don't-care (A).
  function automatic logic rr_pick(input logic req_a, input logic req_b,
                                   input logic last);
    logic pick;
    if (req_a && req_b) begin
      pick = (last == BR_A) ? BR_B : BR_A;
    end else if (req_b) begin
      pick = BR_B;
    end else begin
      pick = BR_A;
    end
    return pick;
  endfunction

endpackage

// File: rtl/sc_sync.sv
// sc_sync
//   STAGES-deep flop chain used to bring an asynchronous level into the CLK
//   domain. Synchronous active-high reset clears every stage. With STAGES=0
//   the input is passed straight through (caller guarantees it is already
//   synchronous).
// Ports:
//   clk  - sampling clock, rising edge
//   rst  - synchronous active-high reset
//   d    - raw input level
//   q    - synchronized level
module sc_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  generate
    if (STAGES == 0) begin : g_pass
      assign q = d;
      // Clock and reset have no load in the pass-through build.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
    end else begin : g_chain
      logic [STAGES-1:0] chain_q;
      logic [STAGES-1:0] chain_d;

      always_comb begin
        chain_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
          chain_d[i] = chain_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          chain_q <= '0;
        end else begin
          chain_q <= chain_d;
        end
      end

      assign q = chain_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/celement_mg.sv
// celement_mg
//   Two-input merge element for the four-phase SEND/ACK token handshake.
//   Tokens from upstream channels A and B are forwarded onto one downstream
//   channel; the acknowledge is returned only to the granted input and BROUT
//   reports which input won. Ties are broken round-robin against LAST.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no transfer open; arbitrate pending requests, grant one
//   REQ   | SENDOUT high, waiting for downstream ACKIN to rise
//   ACKUP | ACKOUTx high, waiting for the granted SENDIN to fall
//   REL   | SENDOUT low, waiting for ACKIN to fall; then CP and back to IDLE
//
// Ports:
//   CLK      - sole clock, rising edge
//   RESET    - synchronous active-high reset
//   SENDINA  - request from upstream A        DATAINA - payload A
//   ACKOUTA  - acknowledge to upstream A
//   SENDINB  - request from upstream B        DATAINB - payload B
//   ACKOUTB  - acknowledge to upstream B
//   SENDOUT  - request to downstream          DATAOUT - forwarded payload
//   BROUT    - granted source (0 = A, 1 = B)
//   ACKIN    - acknowledge from downstream
//   CP       - one-cycle pulse per completed transfer
module celement_mg
  import celement_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SENDINA,
  input  logic [WIDTH-1:0] DATAINA,
  output logic             ACKOUTA,
  input  logic             SENDINB,
  input  logic [WIDTH-1:0] DATAINB,
  output logic             ACKOUTB,
  output logic             SENDOUT,
  output logic [WIDTH-1:0] DATAOUT,
  output logic             BROUT,
  input  logic             ACKIN,
  output logic             CP
);

  // Synchronized handshake levels seen by the FSM.
  logic s_a;
  logic s_b;
  logic s_k;

  sc_sync #(.STAGES(SYNC_STAGES)) u_sync_a (
    .clk (CLK),
    .rst (RESET),
    .d   (SENDINA),
    .q   (s_a)
  );

  sc_sync #(.STAGES(SYNC_STAGES)) u_sync_b (
    .clk (CLK),
    .rst (RESET),
    .d   (SENDINB),
    .q   (s_b)
  );

  sc_sync #(.STAGES(SYNC_STAGES)) u_sync_k (
    .clk (CLK),
    .rst (RESET),
    .d   (ACKIN),
    .q   (s_k)
  );

  state_e           state_q,    state_d;
  logic             send_out_q, send_out_d;
  logic             ack_a_q,    ack_a_d;
  logic             ack_b_q,    ack_b_d;
  logic             cp_q,       cp_d;
  logic             br_q,       br_d;
  logic             last_q,     last_d;
  logic [WIDTH-1:0] data_q,     data_d;

  logic grant_b;
  logic granted_req;

  assign grant_b     = rr_pick(s_a, s_b, last_q);
  // Request level of whichever side currently owns the transfer.
  assign granted_req = (br_q == BR_B) ? s_b : s_a;

  always_comb begin
    state_d    = state_q;
    send_out_d = send_out_q;
    ack_a_d    = ack_a_q;
    ack_b_d    = ack_b_q;
    cp_d       = 1'b0;
    br_d       = br_q;
    last_d     = last_q;
    data_d     = data_q;

    case (state_q)
      IDLE: begin
        if (s_a || s_b) begin
          br_d       = grant_b;
          data_d     = (grant_b == BR_B) ? DATAINB : DATAINA;
          send_out_d = 1'b1;
          state_d    = REQ;
        end
      end

      REQ: begin
        // A withdrawn request here is a peer error; keep waiting for ACKIN.
        if (s_k) begin
          ack_a_d = (br_q == BR_A);
          ack_b_d = (br_q == BR_B);
          state_d = ACKUP;
        end
      end

      ACKUP: begin
        if (!granted_req) begin
          send_out_d = 1'b0;
          state_d    = REL;
        end
      end

      REL: begin
        if (!s_k) begin
          ack_a_d = 1'b0;
          ack_b_d = 1'b0;
          cp_d    = 1'b1;
          last_d  = br_q;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      send_out_q <= 1'b0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      cp_q       <= 1'b0;
      br_q       <= BR_A;
      // LAST starts at B so that A wins the first tie after reset.
      last_q     <= BR_B;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      send_out_q <= send_out_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
      cp_q       <= cp_d;
      br_q       <= br_d;
      last_q     <= last_d;
      data_q     <= data_d;
    end
  end

  // Peer protocol checks. REL only exits with ACKIN low, so ACKIN high while
  // idle means it rose there.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      assert (!(state_q == REQ && !granted_req))
        else $error("celement_mg: granted request withdrawn before ACKIN");
      assert (!(state_q == IDLE && s_k))
        else $error("celement_mg: ACKIN asserted while idle");
    end
  end

  assign SENDOUT = send_out_q;
  assign ACKOUTA = ack_a_q;
  assign ACKOUTB = ack_b_q;
  assign CP      = cp_q;
  assign BROUT   = br_q;
  assign DATAOUT = data_q;

endmodule
